// File: rtl/regblock_ctrl.sv
// Sequences WRITE/READ/COPY/NOP commands onto an 8-entry register block's write and tri-state read ports.
// Latency: WRITE 2 cycles, COPY 3 cycles, READ 2 cycles to rsp_valid; NOP completes on its accept edge.
// Backpressure: cmd_ready low while busy; RESP holds rsp_valid/rsp_data until rsp_ready.
module regblock_ctrl #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_src,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_iaddr,
    output logic [DW-1:0] rf_idata,
    output logic          rf_oe,
    output logic [AW-1:0] rf_oaddr,
    input  logic [DW-1:0] rf_odata,
    output logic [7:0]    op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RESP  = 3'd3,
        S_CP_RD = 3'd4,
        S_CP_WR = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_done;

    logic          r_we;
    logic          r_oe;
    logic          r_rsp_vld;
    logic [AW-1:0] r_iaddr;
    logic [AW-1:0] r_oaddr;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_idata;
    logic [DW-1:0] r_cp_data;
    logic [DW-1:0] r_rsp_data;
    logic [7:0]    r_count;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        2'b01:   w_next = S_WR;
                        2'b10:   w_next = S_RD;
                        2'b11:   w_next = S_CP_RD;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            S_RD:    w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            S_CP_RD: w_next = S_CP_WR;
            S_CP_WR: begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are registered from the next state so they line up exactly with WR/RD/CP_* cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_oe       <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_iaddr    <= '0;
            r_oaddr    <= '0;
            r_dst      <= '0;
            r_idata    <= '0;
            r_cp_data  <= '0;
            r_rsp_data <= '0;
            r_count    <= '0;
        end else begin
            r_we      <= (w_next == S_WR) || (w_next == S_CP_WR);
            r_oe      <= (w_next == S_RD) || (w_next == S_CP_RD);
            r_rsp_vld <= (w_next == S_RESP);
            if (w_accept) begin
                r_dst <= cmd_addr;
                case (cmd_op)
                    2'b01: begin
                        r_iaddr <= cmd_addr;
                        r_idata <= cmd_data;
                    end
                    2'b10:   r_oaddr <= cmd_addr;
                    2'b11:   r_oaddr <= cmd_src;
                    default: ;
                endcase
            end
            // rf_odata is only meaningful (driven) during the read-strobe cycles.
            if (r_state == S_RD) begin
                r_rsp_data <= rf_odata;
            end
            if (r_state == S_CP_RD) begin
                r_cp_data <= rf_odata;
                r_iaddr   <= r_dst;
                r_idata   <= rf_odata;
            end
            if (w_done) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_vld;
    assign rsp_data  = r_rsp_data;
    assign rf_we     = r_we;
    assign rf_oe     = r_oe;
    assign rf_iaddr  = r_iaddr;
    assign rf_idata  = r_idata;
    assign rf_oaddr  = r_oaddr;
    assign op_count  = r_count;

endmodule

// File: doc/regblock_ctrl.md
# regblock_ctrl

Command-driven access controller that sits on the initiator side of the 8-entry register block. It accepts WRITE, READ, COPY and NOP commands over a valid/ready handshake. It sequences the register block's synchronous write port (`we`/`iaddr`/`idata`) and tri-state read port (`oe`/`oaddr`/`odata`), and returns read data over a valid/ready response channel. It also keeps a wrapping count of completed commands for debug.

## Interface
- `AW`, 3: register address width (8 entries).
- `DW`, 8: register data width.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 NOP, 01 WRITE, 10 READ, 11 COPY.
- `cmd_addr`  in  AW  WRITE/COPY destination, READ source.
- `cmd_src`  in  AW  COPY source; ignored otherwise.
- `cmd_data`  in  DW  WRITE data; ignored otherwise.
- `rsp_valid`  out  1  READ result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  DW  READ result.
- `rf_we`  out  1  to register block `we`.
- `rf_iaddr`  out  AW  to register block `iaddr`.
- `rf_idata`  out  DW  to register block `idata`.
- `rf_oe`  out  1  to register block `oe`.
- `rf_oaddr`  out  AW  to register block `oaddr`.
- `rf_odata`  in  DW  from register block `odata`; Z when `rf_oe`=0.
- `op_count`  out  8  completed non-NOP commands, wraps 255→0.

## Operation
- States: IDLE, WR, RD, RESP, CP_RD, CP_WR.
- `cmd_ready` = (state==IDLE). A command is accepted on a posedge with `cmd_valid && cmd_ready`. `cmd_addr`/`cmd_src`/`cmd_data` are latched on acceptance.
- NOP: accepted, no port activity, stays IDLE, `op_count` unchanged.
- WRITE: IDLE→WR.
  - WR drives `rf_we`=1, `rf_iaddr`=addr, `rf_idata`=data for exactly one cycle.
  - WR→IDLE. `op_count`+1 on the WR exit edge.
- READ: IDLE→RD.
  - RD drives `rf_oe`=1, `rf_oaddr`=addr; `rf_odata` is captured into `rsp_data` at the end of RD.
  - RD→RESP. RESP holds `rsp_valid`=1 with `rsp_data` stable until `rsp_ready`=1.
  - RESP→IDLE on the handshake edge; `op_count`+1 there.
- COPY: IDLE→CP_RD.
  - CP_RD: `rf_oe`=1, `rf_oaddr`=src; capture `rf_odata` into the internal data register.
  - CP_WR: `rf_we`=1, `rf_iaddr`=dst, `rf_idata`=captured value.
  - CP_WR→IDLE; `op_count`+1. No response is generated.
  - src==dst performs the full read+write; the register value is unchanged.
- `rf_oe`=0 outside RD/CP_RD, so the bus floats. `rf_odata` is never sampled outside RD/CP_RD.
- `rf_we`=0 outside WR/CP_WR. `rf_we` and `rf_oe` are never both 1.
- `rf_iaddr`/`rf_idata`/`rf_oaddr` hold their last values when not strobed.
- Reset (async, any state): state→IDLE.
  - Pending response discarded; a partially executed COPY is abandoned (no write if reset lands before CP_WR).
  - `op_count` cleared.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rf_we`=0, `rf_oe`=0, `rf_iaddr`=0, `rf_oaddr`=0, `rf_idata`=0, `op_count`=0.
- Control outputs (`rf_we`, `rf_oe`, addresses, data) are registered, with no combinational path from `cmd_*` to `rf_*`.
- WRITE accepted at edge t: `rf_we` high in cycle t..t+1; register updated at edge t+1 → t+2. Next accept is possible at edge t+2 (2 cycles/command).
- READ accepted at edge t: `rf_oe` high during the following cycle; `rsp_valid` rises after the next edge. With `rsp_ready` held high, the next accept comes 3 edges after t.
- COPY accepted at edge t: CP_RD in the next cycle, CP_WR in the one after, next accept 3 edges after t.
- A READ issued after a WRITE to the same address returns the new value; the write has completed before RD.
- `rsp_ready` is ignored when `rsp_valid`=0. `cmd_valid` is ignored when `cmd_ready`=0.
- `op_count` 255 + 1 → 0.

## Test plan
- Reset: pulse `rst_n` low asynchronously mid-cycle while in RESP → all outputs go to reset values immediately; `cmd_ready`=1; `rsp_valid`=0.
- Write then read: WRITE addr 3 data 0xA5, then READ addr 3 with a behavioural register-block model → exactly one `rf_we` cycle with `rf_iaddr`=3, `rf_idata`=0xA5; `rsp_data`=0xA5; `op_count`=2.
- COPY src 3 → dst 0 (entry 3 = 0xA5) → one `rf_oe` cycle with `rf_oaddr`=3, then one `rf_we` cycle with `rf_iaddr`=0, `rf_idata`=0xA5. Entry 0 reads 0xA5; `rsp_valid` never asserts.
- Backpressure: READ with `rsp_ready` low for 5 cycles → `rsp_valid` high and `rsp_data` stable all 5 cycles; `cmd_ready`=0; `rf_oe`=0 during RESP.
- Counter: 256 WRITEs interleaved with 10 NOPs → `op_count` returns to 0; NOPs complete with no `rf_we`/`rf_oe` pulses.
- Reset during CP_RD of COPY 2→5 → no `rf_we` pulse at any time; entry 5 unchanged; controller accepts the next command normally.
